debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of independent button channels (min 1).
REQ-002 The block SHALL have parameter TICK_BITS, default 19, prescaler width; tick period P = 2^TICK_BITS clocks (min 1).
REQ-003 The block SHALL have parameter STABLE_TICKS, default 3, consecutive disagreeing ticks needed to accept a new level (min 1).
REQ-004 The block SHALL have parameter HOLD_TICKS, default 0, ticks at level 1 before held asserts; 0 disables held.
REQ-005 The block SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (min 2).
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 button  input  CHANNELS  raw asynchronous button inputs, active-high.
REQ-009 level  output  CHANNELS  debounced button level, registered.
REQ-010 press  output  CHANNELS  one-cycle pulse on debounced 0->1, registered.
REQ-011 release  output  CHANNELS  one-cycle pulse on debounced 1->0, registered.
REQ-012 held  output  CHANNELS  high while level has been 1 for >= HOLD_TICKS ticks.
REQ-013 any_press  output  1  OR of press, registered with press.

Function
REQ-014 Each channel SHALL pass button through a SYNC_STAGES-deep flop chain; sample s[i] is the last stage.
REQ-015 A single shared prescaler SHALL count 0..P-1 and wrap; tick is high in the cycle the count is all-ones.
REQ-016 Per channel, a counter SHALL clear in any cycle where s[i] == level[i], regardless of tick (abort has priority).
REQ-017 Per channel, when s[i] != level[i] and tick is high, the counter SHALL increment; on reaching STABLE_TICKS, level[i] <= s[i] and counter clears on the same edge.
REQ-018 press[i] SHALL be high exactly in the first cycle level[i] reads 1; release[i] exactly in the first cycle level[i] reads 0 after being 1.
REQ-019 Acceptance latency from the s[i] change SHALL be (STABLE_TICKS-1)*P+1 to STABLE_TICKS*P clocks; input-to-level adds SYNC_STAGES.
REQ-020 A disagreement lasting fewer than (STABLE_TICKS-1)*P+1 clocks SHALL never change level.
REQ-021 Per channel, a hold counter SHALL increment on tick while level[i]=1, saturate at HOLD_TICKS, and clear when level[i]=0.
REQ-022 held[i] SHALL be 1 while the hold counter equals HOLD_TICKS and HOLD_TICKS>0; held[i] SHALL fall in the same cycle level[i] falls.
REQ-023 With HOLD_TICKS=0 held SHALL be constant 0 and no hold counter SHALL be built.
REQ-024 Channels SHALL be fully independent; simultaneous acceptance on several channels SHALL produce simultaneous press/release bits.
REQ-025 Counter widths SHALL be sized from STABLE_TICKS and HOLD_TICKS with no overflow or wrap for any legal parameter value.

Reset
REQ-026 With reset_n=0 at a rising edge: prescaler, sync chain, all counters, level, press, release, held, any_press SHALL be 0 in the following cycle.
REQ-027 Reset asserted mid-acceptance or mid-hold SHALL discard progress; no press/release pulse SHALL be emitted as a result of reset.
REQ-028 A button already high at reset release SHALL be treated as a new 0->1 change and produce press after normal latency.

Verification (TICK_BITS=2 so P=4, STABLE_TICKS=3, HOLD_TICKS=4, SYNC_STAGES=2, CHANNELS=4)
REQ-029 button[0] 0->1 and held -> level[0]=1 and single-cycle press[0], any_press 11-14 clocks after input edge; other channels stay 0.
REQ-030 button[1] high for 5 clocks then low -> level, press, release of channel 1 all stay 0.
REQ-031 button[2] pressed until level=1, then bounced low 3 clocks and high again repeatedly -> no release; clean low -> single release[2] 11-14 clocks after final fall.
REQ-032 button[3] held -> held[3] rises 13-16 clocks after level[3] rises; on release held[3] falls same cycle as level[3].
REQ-033 buttons 0 and 3 rise on the same edge -> press[0] and press[3] high in the same cycle, any_press one cycle.
REQ-034 reset_n pulsed low for 1 clock with level[0]=1 and held[0]=1 -> all outputs 0 next cycle, no release pulse; button still high -> press[0] again after 11-14 clocks.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: bank of independent push-button debouncers sharing one
// prescaler tick.
//
// Each channel synchronises its raw input, then accepts a new level only
// after the synchronised sample has disagreed with the current level for
// STABLE_TICKS consecutive prescaler ticks. Any cycle of agreement aborts
// the attempt. Optional hold detection asserts `held` once the level has
// stayed high for HOLD_TICKS ticks.
//
// Ports:
//   clock         sole clock, rising edge
//   reset_n       synchronous active-low reset
//   button        raw asynchronous inputs, active-high, one bit per channel
//   level         debounced level, registered
//   press         one-cycle pulse in the first cycle level reads 1
//   release_pulse one-cycle pulse in the first cycle level reads 0 after 1
//                 (the bare word `release` is reserved in the language)
//   held          level has been 1 for >= HOLD_TICKS ticks (0 if disabled)
//   any_press     OR of press, same timing as press
module debounce_bank #(
  parameter int CHANNELS     = 4,
  parameter int TICK_BITS    = 19,
  parameter int STABLE_TICKS = 3,
  parameter int HOLD_TICKS   = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] held,
  output logic                any_press
);

  localparam int STABLE_W = $clog2(STABLE_TICKS + 1);

  logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]  sample;
  logic [TICK_BITS-1:0] presc;
  logic                 tick;
  logic [STABLE_W-1:0]  stable_cnt [CHANNELS];
  logic [CHANNELS-1:0]  accept;

  assign sample = sync_q[SYNC_STAGES-1];
  assign tick   = &presc;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= button;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) presc <= '0;
    else          presc <= presc + TICK_BITS'(1);
  end

  // A channel flips on the tick that would take its counter to STABLE_TICKS;
  // the counter is cleared on that same edge instead of being stored.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      accept[i] = (sample[i] != level[i]) && tick &&
                  (stable_cnt[i] == STABLE_W'(STABLE_TICKS - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) stable_cnt[i] <= '0;
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      any_press     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sample[i] == level[i])  stable_cnt[i] <= '0;
        else if (accept[i])         stable_cnt[i] <= '0;
        else if (tick)              stable_cnt[i] <= stable_cnt[i] + STABLE_W'(1);
      end
      level         <= level ^ accept;
      press         <= accept & sample;
      release_pulse <= accept & ~sample;
      any_press     <= |(accept & sample);
    end
  end

  generate
    if (HOLD_TICKS > 0) begin : g_hold
      localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
      logic [HOLD_W-1:0] hold_cnt [CHANNELS];

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          for (int unsigned i = 0; i < CHANNELS; i++) hold_cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!level[i])
              hold_cnt[i] <= '0;
            else if (tick && hold_cnt[i] != HOLD_W'(HOLD_TICKS))
              hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
          end
        end
      end

      // Gating with level makes held drop in the same cycle level drops,
      // one cycle before the hold counter itself clears.
      always_comb begin
        held = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          held[i] = level[i] && (hold_cnt[i] == HOLD_W'(HOLD_TICKS));
        end
      end
    end else begin : g_no_hold
      assign held = '0;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank with P=4, STABLE_TICKS=3, HOLD_TICKS=4,
// SYNC_STAGES=2, CHANNELS=4. Stimulus pushes expected output events with
// cycle windows; a monitor pops one entry per observed press/release/held
// rise and checks the full output vector.
module tb_debounce_bank;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] button = '0;
  logic [3:0] level, press, release_pulse, held;
  logic       any_press;

  always #5 clock = ~clock;

  debounce_bank #(
    .CHANNELS(4), .TICK_BITS(2), .STABLE_TICKS(3), .HOLD_TICKS(4), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .button(button), .level(level),
    .press(press), .release_pulse(release_pulse), .held(held), .any_press(any_press)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [3:0] press, rel, level, held;
    logic       any;
    int         lo, hi, ref_ch;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;
  int   last_press[4];
  logic [3:0] held_prev;

  task automatic push(input string nm, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] h, input logic a,
                      input int lo, input int hi, input int ref_ch);
    exp_t e;
    e.name = nm; e.press = p; e.rel = r; e.level = l; e.held = h; e.any = a;
    e.lo = lo; e.hi = hi; e.ref_ch = ref_ch;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_level"}, level, 4'b0000);
    chk({nm, "_press"}, press, 4'b0000);
    chk({nm, "_release"}, release_pulse, 4'b0000);
    chk({nm, "_held"}, held, 4'b0000);
    chk({nm, "_any"}, {3'b000, any_press}, 4'b0000);
  endtask

  // Monitor
  initial begin
    held_prev = '0;
    for (int i = 0; i < 4; i++) last_press[i] = 0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (press != 0 || release_pulse != 0 || (held & ~held_prev) != 0) begin
          for (int c = 0; c < 4; c++) if (press[c]) last_press[c] = cyc;
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: cyc=%0d press=%b release=%b held=%b level=%b, expected no event",
                     cyc, press, release_pulse, held, level);
          end else begin
            exp_t e;
            int lo, hi;
            e = q.pop_front();
            lo = e.lo; hi = e.hi;
            if (e.ref_ch >= 0) begin
              lo = last_press[e.ref_ch] + e.lo;
              hi = last_press[e.ref_ch] + e.hi;
            end
            if (press !== e.press || release_pulse !== e.rel || level !== e.level ||
                held !== e.held || any_press !== e.any || cyc < lo || cyc > hi) begin
              bad++;
              $display("FAIL %s: got cyc=%0d press=%b release=%b level=%b held=%b any=%b; expected cyc %0d..%0d press=%b release=%b level=%b held=%b any=%b",
                       e.name, cyc, press, release_pulse, level, held, any_press,
                       lo, hi, e.press, e.rel, e.level, e.held, e.any);
            end
          end
        end else begin
          total++;
          if (any_press !== 1'b0) begin
            bad++;
            $display("FAIL any_press_quiet: cyc=%0d got %b expected 0", cyc, any_press);
          end
        end
      end
      held_prev = held;
    end
  end

  // Stimulus
  initial begin
    reset_n = 1'b0;
    button  = '0;
    step(3);
    check_zero("reset_state");
    reset_n = 1'b1;
    mon_en  = 1;

    // channel 0 press and hold
    button[0] = 1'b1;
    push("press0", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, cyc + 11, cyc + 14, -1);
    push("held0", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 13, 16, 0);
    step(40);

    // one-cycle reset with level[0]=held[0]=1, button still high
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check_zero("pulse_reset");
    push("repress0", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, cyc + 11, cyc + 14, -1);
    push("reheld0", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 13, 16, 0);
    step(40);

    // channel 0 release
    button[0] = 1'b0;
    push("release0", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, cyc + 11, cyc + 14, -1);
    step(30);

    // short glitch on channel 1 never accepted
    button[1] = 1'b1;
    step(5);
    button[1] = 1'b0;
    step(30);
    chk("glitch_level", level, 4'b0000);

    // channel 3 hold then release
    button[3] = 1'b1;
    push("press3", 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b1, cyc + 11, cyc + 14, -1);
    push("held3", 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 13, 16, 3);
    step(40);
    button[3] = 1'b0;
    push("release3", 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0, cyc + 11, cyc + 14, -1);
    step(30);

    // channel 2 press, bounce low for 3 clocks repeatedly, then clean release
    button[2] = 1'b1;
    push("press2", 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1, cyc + 11, cyc + 14, -1);
    push("held2", 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0, 13, 16, 2);
    step(25);
    for (int b = 0; b < 5; b++) begin
      button[2] = 1'b0;
      step(3);
      button[2] = 1'b1;
      step(3);
    end
    button[2] = 1'b0;
    push("release2", 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, cyc + 11, cyc + 14, -1);
    step(30);

    // channels 0 and 3 together
    button = 4'b1001;
    push("press03", 4'b1001, 4'b0000, 4'b1001, 4'b0000, 1'b1, cyc + 11, cyc + 14, -1);
    push("held03", 4'b0000, 4'b0000, 4'b1001, 4'b1001, 1'b0, 13, 16, 0);
    step(40);
    button = 4'b0000;
    push("release03", 4'b0000, 4'b1001, 4'b0000, 4'b0000, 1'b0, cyc + 11, cyc + 14, -1);
    step(30);

    mon_en = 0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d unmatched expectations, expected 0 (next %s)",
               q.size(), q[0].name);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
